// File: rtl/panel_scroll_if.sv
// Panel scroll control bus: run/step controls toward the scroll controller and
// the shared cell select code, shift strobe and scroll position back out.
//   en, dir, speed, step : controls driven by the master (host/sequencer)
//   sel0, sel1           : select code broadcast to every panel cell
//   shift, wrap          : one-cycle strobes while a shift code is presented
//   pos                  : current scroll position, 0..N_COLS-1
interface panel_scroll_if #(
    parameter int POS_W = 3
);
    logic             en;
    logic             dir;
    logic [1:0]       speed;
    logic             step;
    logic             sel0;
    logic             sel1;
    logic             shift;
    logic             wrap;
    logic [POS_W-1:0] pos;

    modport master (
        output en, dir, speed, step,
        input  sel0, sel1, shift, pos, wrap
    );

    modport slave (
        input  en, dir, speed, step,
        output sel0, sel1, shift, pos, wrap
    );
endinterface

// File: rtl/panel_scroll_ctrl.sv
// Timing/control end of the panel shift chain. Produces the shared {sel1,sel0}
// code (01 hold, 10 take previous neighbour, 11 take next neighbour), issues
// one-cycle shifts at a programmable rate or on a manual step edge, and tracks
// the scroll position modulo N_COLS.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : panel_scroll_if slave (en/dir/speed/step in; sel/shift/wrap/pos out)
// All outputs come straight from flops; nothing from the inputs reaches them
// combinationally.
module panel_scroll_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int N_COLS  = 8,
    parameter int POS_W   = 3
) (
    input logic           clk,
    input logic           rst,
    panel_scroll_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, RUN, SHIFT} state_t;

    state_t           state, state_nx;
    logic [PW-1:0]    presc, presc_nx;
    logic [POS_W-1:0] pos, pos_nx;
    logic [1:0]       sel, sel_nx;
    logic             shift, shift_nx;
    logic             wrap, wrap_nx;
    logic             sdir, sdir_nx;
    logic             step_q;
    logic             step_edge;
    logic [31:0]      term;
    logic             at_term;

    // Terminal count follows speed live; ">=" makes a speed-up that leaves the
    // count beyond the new terminal fire on the next decision edge.
    assign term      = (32'(CLK_DIV) >> bus.speed) - 32'd1;
    assign at_term   = 32'(presc) >= term;
    assign step_edge = bus.step & ~step_q;

    always_comb begin
        state_nx = state;
        presc_nx = presc;
        pos_nx   = pos;
        sdir_nx  = sdir;
        sel_nx   = 2'b01;
        shift_nx = 1'b0;
        wrap_nx  = 1'b0;
        case (state)
            IDLE: begin
                // en takes priority over a coincident step edge
                if (bus.en) begin
                    state_nx = RUN;
                    presc_nx = '0;
                end else if (step_edge) begin
                    state_nx = SHIFT;
                end
            end
            RUN: begin
                // pausing beats a same-cycle terminal count
                if (!bus.en) begin
                    state_nx = IDLE;
                    presc_nx = '0;
                end else if (at_term) begin
                    state_nx = SHIFT;
                    presc_nx = '0;
                end else begin
                    presc_nx = presc + PW'(1);
                end
            end
            SHIFT: begin
                state_nx = bus.en ? RUN : IDLE;
                presc_nx = '0;
                if (sdir)
                    pos_nx = (pos == '0) ? POS_W'(N_COLS - 1) : pos - POS_W'(1);
                else
                    pos_nx = (pos == POS_W'(N_COLS - 1)) ? '0 : pos + POS_W'(1);
            end
            default: state_nx = IDLE;
        endcase

        // dir is captured at the decision edge and held for the SHIFT cycle;
        // pos is stable until the edge that ends SHIFT, so wrap uses it here.
        if (state_nx == SHIFT) begin
            sdir_nx  = bus.dir;
            sel_nx   = {1'b1, bus.dir};
            shift_nx = 1'b1;
            wrap_nx  = bus.dir ? (pos == '0) : (pos == POS_W'(N_COLS - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            presc  <= '0;
            pos    <= '0;
            sel    <= 2'b00;
            shift  <= 1'b0;
            wrap   <= 1'b0;
            sdir   <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nx;
            presc  <= presc_nx;
            pos    <= pos_nx;
            sel    <= sel_nx;
            shift  <= shift_nx;
            wrap   <= wrap_nx;
            sdir   <= sdir_nx;
            step_q <= bus.step;
        end
    end

    assign bus.sel0  = sel[0];
    assign bus.sel1  = sel[1];
    assign bus.shift = shift;
    assign bus.wrap  = wrap;
    assign bus.pos   = pos;
endmodule
